// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: N AXI4-Stream sources share one master port,
// holding each grant from the first beat through TLAST.
//
// state  | meaning
// IDLE   | no grant held; pick the next requester after last_grant (one dead cycle)
// LOCKED | input grant_idx is passed straight through to M_AXIS until its TLAST beat
module axis_pkt_rr_arbiter #(
    parameter int C_NUM_INPUTS       = 4,
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                         ACLK,
    input  logic                                         ARESET,
    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic [C_NUM_INPUTS-1:0]                      S_AXIS_TVALID,
    output logic [C_NUM_INPUTS-1:0]                      S_AXIS_TREADY,
    input  logic [C_NUM_INPUTS-1:0]                      S_AXIS_TLAST,
    output logic [C_AXIS_DATA_WIDTH-1:0]                 M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]               M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                M_AXIS_TUSER,
    output logic                                         M_AXIS_TVALID,
    input  logic                                         M_AXIS_TREADY,
    output logic                                         M_AXIS_TLAST,
    input  logic [C_NUM_INPUTS-1:0]                      port_enable,
    input  logic                                         count_reset,
    output logic [2:0]                                   grant_idx,
    output logic                                         busy,
    output logic [31:0]                                  pkt_count
);

    localparam int W  = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                    state;
    logic [2:0]                last_grant;
    logic [C_NUM_INPUTS-1:0]   req;
    logic [2:0]                win_idx;
    logic                      win_valid;
    logic                      pkt_done;

    function automatic int wrap_idx(input int v);
        return (v >= C_NUM_INPUTS) ? v - C_NUM_INPUTS : v;
    endfunction

    assign req = S_AXIS_TVALID & port_enable;

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        for (int off = C_NUM_INPUTS; off >= 1; off--) begin
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (req[i] && (i == wrap_idx(int'(last_grant) + off))) begin
                    win_idx   = 3'(i);
                    win_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        S_AXIS_TREADY = '0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TUSER  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        if (state == LOCKED) begin
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (grant_idx == 3'(i)) begin
                    M_AXIS_TDATA     = S_AXIS_TDATA[i*W +: W];
                    M_AXIS_TSTRB     = S_AXIS_TSTRB[i*SW +: SW];
                    M_AXIS_TUSER     = S_AXIS_TUSER[i*UW +: UW];
                    M_AXIS_TVALID    = S_AXIS_TVALID[i];
                    M_AXIS_TLAST     = S_AXIS_TLAST[i];
                    S_AXIS_TREADY[i] = M_AXIS_TREADY;
                end
            end
        end
    end

    assign pkt_done = (state == LOCKED) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            last_grant <= 3'(C_NUM_INPUTS - 1);
            grant_idx  <= 3'(C_NUM_INPUTS - 1);
            busy       <= 1'b0;
            pkt_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        state     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (pkt_done) begin
                        last_grant <= grant_idx;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A clear wins over a packet completing in the same cycle.
            if (count_reset)
                pkt_count <= '0;
            else if (pkt_done)
                pkt_count <= pkt_count + 32'd1;
        end
    end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI4-Stream master port between C_NUM_INPUTS stream sources, e.g. several packet generators feeding one 10G MAC or checker.
- A grant is held from the first beat of a packet through the beat with TLAST, so packets are never interleaved.
- Provides per-input enables and a forwarded-packet counter for the AXI-Lite register block.

Parameters:
- C_NUM_INPUTS, 4, number of slave stream inputs (2..8).
- C_AXIS_DATA_WIDTH, 64, TDATA width per stream.
- C_AXIS_TUSER_WIDTH, 128, TUSER width per stream.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  C_NUM_INPUTS*C_AXIS_DATA_WIDTH  flattened; input i occupies slice [i*W +: W].
- S_AXIS_TSTRB  in  C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8  flattened byte strobes.
- S_AXIS_TUSER  in  C_NUM_INPUTS*C_AXIS_TUSER_WIDTH  flattened sideband.
- S_AXIS_TVALID  in  C_NUM_INPUTS  per-input valid.
- S_AXIS_TREADY  out  C_NUM_INPUTS  per-input ready.
- S_AXIS_TLAST  in  C_NUM_INPUTS  per-input last.
- M_AXIS_TDATA  out  C_AXIS_DATA_WIDTH  arbitrated data.
- M_AXIS_TSTRB  out  C_AXIS_DATA_WIDTH/8  arbitrated strobes.
- M_AXIS_TUSER  out  C_AXIS_TUSER_WIDTH  arbitrated sideband.
- M_AXIS_TVALID  out  1  arbitrated valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  arbitrated last.
- port_enable  in  C_NUM_INPUTS  1 = input eligible for new grants.
- count_reset  in  1  clears pkt_count.
- grant_idx  out  3  index of the current or last granted input.
- busy  out  1  1 while a packet grant is held.
- pkt_count  out  32  packets forwarded (TLAST handshakes on M).

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESET is synchronous and active-high.
- Reset values:
  - state = IDLE, last_grant = C_NUM_INPUTS-1, so input 0 has first priority.
  - grant_idx = C_NUM_INPUTS-1, busy = 0, pkt_count = 0.
  - All S_AXIS_TREADY = 0, M_AXIS_TVALID = 0, M_AXIS_TDATA/TSTRB/TUSER/TLAST = 0.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - All S_AXIS_TREADY = 0, M_AXIS_TVALID = 0, M_AXIS payload driven to 0.
  - Request vector req = S_AXIS_TVALID & port_enable.
  - If req != 0, choose the first set bit searching cyclically from last_grant+1, wrapping at C_NUM_INPUTS-1 -> 0.
  - Register the winner into grant_idx and go to LOCKED next cycle.
  - No beat transfers in the IDLE cycle, so arbitration costs exactly 1 dead cycle per packet.
- LOCKED, with g = grant_idx:
  - M_AXIS_TDATA/TSTRB/TUSER/TLAST/TVALID are combinationally equal to input g's signals.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other TREADY = 0.
  - Pass-through has zero latency and no buffering.
  - busy = 1.
- Packet end: a beat with M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST causes:
  - state -> IDLE next cycle, last_grant <= g, pkt_count += 1 (wraps modulo 2^32).
- port_enable deasserted for g mid-packet: no effect; the packet completes. The input only becomes ineligible at the next arbitration.
- Source g dropping TVALID mid-packet: the grant is held indefinitely; there is no timeout and no abort.
- count_reset:
  - Clears pkt_count the next cycle and takes priority over a simultaneous increment.
  - Does not affect FSM, grant or data flow.
- Reset mid-packet: immediately returns to reset values; the partial packet is truncated on M (no TLAST emitted). Sources are responsible for flushing.
- TSTRB and TUSER are passed unmodified; the block never inspects data.
- Single-beat packets (TVALID & TLAST on the first beat) are legal: LOCKED lasts 1 cycle if M_AXIS_TREADY = 1.

Test Plan:
- Reset priority: after reset, inputs 0 and 2 both valid, 4-beat packets, M ready = 1. Required: input 0 forwarded first (cycles 2-5), IDLE cycle 6, then input 2 (cycles 7-10); pkt_count = 2, grant_idx = 2.
- Round-robin fairness: all 4 inputs continuously valid with 16-beat packets, port_enable = 4'b1111. Required: grant order 0,1,2,3,0,…; after 8 packets pkt_count = 8, each input served exactly twice, exactly one dead cycle between packets.
- Backpressure: input 1 only, 16-beat packet, M_AXIS_TREADY toggles 1,0,1,0. Required: data beats match the source exactly in order; S_AXIS_TREADY[1] mirrors M_AXIS_TREADY; TLAST on beat 16 only; pkt_count += 1.
- Enable masking:
  - port_enable = 4'b1010 with all inputs valid -> only inputs 1 and 3 are granted.
  - Clearing bit 1 during input 1's packet -> that packet still completes, then input 1 is never granted again.
- Counter reset collision: count_reset asserted in the same cycle as a TLAST handshake with pkt_count = 5. Required: pkt_count = 0 next cycle, not 1.
- Reset mid-packet: ARESET asserted on beat 7 of 16 for input 2. Required next cycle: M_AXIS_TVALID = 0, all TREADY = 0, busy = 0, pkt_count = 0. On the next request input 0 wins over input 3.
